vga_frame_receiver: RTL and testbench
=====================================

# vga_frame_receiver

Receive-side counterpart of the VGA driver. Consumes the driver's raster outputs (hsync, vsync, blank, red, green, blue), sampled once per pixel clock. Recovers pixel coordinates from sync edges and checks the raster against 640x480 timing, locking after one clean frame. Emits a per-pixel stream of {x, y, RGB}, used as a self-checking frame capture in graphics benches and as a loopback monitor on the board.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync, back porch (H_TOTAL = 800)
- V_ACTIVE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync, back porch (V_TOTAL = 525)
- clk  in  1  pixel clock; all inputs sampled on the rising edge
- rst  in  1  asynchronous, active-low reset
- hsync  in  1  horizontal sync, active-low
- vsync  in  1  vertical sync, active-low
- blank  in  1  active-low blank (0 = blanking interval)
- red, green, blue  in  8 each  pixel colour
- pix_valid  out  1  pix_* carry an active pixel
- pix_x  out  10  column 0..639
- pix_y  out  10  row 0..479
- pix_rgb  out  24  {red, green, blue}
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0)
- locked  out  1  FSM in LOCKED
- line_err  out  1  one-cycle pulse: hsync period != H_TOTAL
- frame_err  out  1  one-cycle pulse: line count != V_TOTAL
- blank_err  out  1  sticky: blank disagrees with recovered timing

## Operation
- Input stage registers all inputs. An hsync fall is a sample of 0 following a sample of 1; vsync falls are detected the same way.
- h_cnt: set to 0 on the sample carrying the hsync fall, otherwise incremented, saturating at 1023.
- vsync fall sets v_arm. v_cnt is reset to 0 on the next hsync fall, or the same one if coincident; v_arm clears at that point. Other hsync falls increment v_cnt, saturating at 1023.
- Line check is enabled once one hsync fall has been seen since reset:
  - hsync fall with h_cnt != H_TOTAL-1 gives line_err.
  - h_cnt reaching H_TOTAL with no fall gives line_err, raised once per missing edge.
- Frame check: a v_cnt reset with previous v_cnt != V_TOTAL-1 gives frame_err. This check is skipped on the first reset after SEARCH.
- FSM states, reset to SEARCH:
  - SEARCH: on v_cnt reset, go to MEASURE.
  - MEASURE: line_err or frame_err returns to SEARCH. The next v_cnt reset with no error during the frame goes to LOCKED.
  - LOCKED: any line_err or frame_err returns to SEARCH in the following cycle.
- Active pixel: LOCKED and h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] = [144, 783] and v_cnt in [V_SYNC+V_BP, +V_ACTIVE-1] = [35, 514].
  - pix_x = h_cnt-144, pix_y = v_cnt-35.
  - Subtraction is 10-bit unsigned and is only evaluated inside the window.
- blank_err sets if, while LOCKED, the sampled blank != active. It clears only on reset.
- Outside active pixels, pix_x, pix_y and pix_rgb hold their last value.

## Timing
- Reset: every output is 0. FSM in SEARCH, counters 0, the first-hsync flag clear, v_arm clear.
- Latency: a sample present at edge k is reflected on pix_*, frame_start and the error pulses after edge k+2. locked changes in that same cycle.
- Throughput: one pixel per clk, no stalls, no back-pressure.
- Lock time from reset with a clean raster:
  - First vsync fall enters MEASURE.
  - The next frame boundary asserts locked.
  - First pix_valid is the first active pixel of the following frame, at the earliest 2 frames after reset.
- Error detected on the pixel where the FSM drops: pix_valid is already 0 for that pixel.
- Simultaneous hsync and vsync falls: v_cnt resets on that very line, which is line 0.
- Reset mid-frame: outputs clear immediately (asynchronous). The block re-locks as from power-up.

## Structure
- Package vga_rx_pkg holds:
  - 640x480 timing localparams and the derived H_TOTAL, V_TOTAL and active-window bounds
  - typedef rgb_t (24-bit packed struct {r, g, b})
  - enum rx_state_t {SEARCH, MEASURE, LOCKED}
- One sub-module, vga_period_counter: edge detect, saturating counter and period-mismatch pulse.
  - Instantiated twice: horizontal (clocked every cycle) and vertical (enabled on the hsync fall).
- Top level holds the input stage, FSM, active-window decode and output registers.

## Test plan
- Clean raster from the VGA driver with a random colour pattern:
  - locked rises at the second frame boundary.
  - Exactly 307200 pix_valid per frame.
  - pix_rgb matches the pattern at every (x, y).
  - frame_start coincides with (0,0).
- Drop one hsync fall in line 200 of a locked frame:
  - line_err pulses once, locked falls.
  - pix_valid stays low until relock two frame boundaries later.
- Frame of 524 lines:
  - frame_err at the short boundary, FSM to SEARCH, no pix_valid in that frame.
- Force blank low at (x=10, y=20) while locked:
  - blank_err sets 2 cycles later and stays set.
  - pixel data is unaffected.
- Assert rst for 3 cycles mid-line while locked:
  - All outputs 0 asynchronously.
  - Relock timing identical to power-up.
- vsync fall coincident with hsync fall vs. 50 cycles earlier:
  - pix_y=0 maps to the same physical line in both cases.

Source files
------------

// File: rtl/vga_rx_pkg.sv
// Shared definitions for the VGA frame receiver.
// Holds the 640x480 raster timing, the derived totals and active-window bounds,
// the pixel colour type and the lock FSM state encoding.
package vga_rx_pkg;

    // Horizontal timing, in pixel clocks
    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    // Vertical timing, in lines
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Active window, counted from the sync falling edge
    localparam int unsigned H_WIN_LO = H_SYNC + H_BP;
    localparam int unsigned H_WIN_HI = H_WIN_LO + H_ACTIVE - 1;
    localparam int unsigned V_WIN_LO = V_SYNC + V_BP;
    localparam int unsigned V_WIN_HI = V_WIN_LO + V_ACTIVE - 1;

    // Width of the position counters and coordinate outputs
    localparam int unsigned CNT_W = 10;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        SEARCH,
        MEASURE,
        LOCKED
    } rx_state_t;

endpackage

// File: rtl/vga_frame_receiver_if.sv
// Raster-in / pixel-out bundle of the VGA frame receiver.
// master: raster source and pixel consumer (bench or board glue).
// slave:  the receiver (takes hsync/vsync/blank/RGB, drives pix_* and status).
interface vga_frame_receiver_if;
    import vga_rx_pkg::*;

    // Raster from the VGA driver
    logic             hsync;
    logic             vsync;
    logic             blank;
    logic [7:0]       red;
    logic [7:0]       green;
    logic [7:0]       blue;

    // Recovered pixel stream and status
    logic             pix_valid;
    logic [CNT_W-1:0] pix_x;
    logic [CNT_W-1:0] pix_y;
    rgb_t             pix_rgb;
    logic             frame_start;
    logic             locked;
    logic             line_err;
    logic             frame_err;
    logic             blank_err;

    modport master (
        output hsync, vsync, blank, red, green, blue,
        input  pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked,
        input  line_err, frame_err, blank_err
    );

    modport slave (
        input  hsync, vsync, blank, red, green, blue,
        output pix_valid, pix_x, pix_y, pix_rgb, frame_start, locked,
        output line_err, frame_err, blank_err
    );

endinterface

// File: rtl/vga_period_counter.sv
// Sync-edge position counter with period check.
// Detects the falling edge of a registered active-low sync, arms on it, and on the
// next tick restarts a saturating counter. A restart whose previous count was not
// Period-1 flags a mismatch; optionally, counting past Period-1 without a restart
// flags an overrun once, and the late edge that follows is not reported again.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   sync_i         registered sync level (active-low)
//   tick_i         count enable (every cycle, or once per line)
//   check_i        allows period errors to be reported
//   restart_o      combinational: this tick restarts the counter
//   count_o        counter value for the current sample
//   restarted_o    registered restart, aligned with count_o == 0
//   err_o          registered period error pulse, aligned with count_o
module vga_period_counter
    import vga_rx_pkg::*;
#(
    parameter int unsigned Width        = CNT_W,
    parameter int unsigned Period       = H_TOTAL,
    parameter bit          CheckOverrun = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             sync_i,
    input  logic             tick_i,
    input  logic             check_i,
    output logic             restart_o,
    output logic [Width-1:0] count_o,
    output logic             restarted_o,
    output logic             err_o
);

    localparam logic [Width-1:0] LastCnt = Width'(Period - 1);
    localparam logic [Width-1:0] MaxCnt  = '1;

    logic             sync_prev_q;
    logic             arm_q, arm_d;
    logic             seen_q, seen_d;
    logic             ovr_q, ovr_d;
    logic [Width-1:0] cnt_q, cnt_d;
    logic             restarted_q;
    logic             err_q, err_d;
    logic             fall;
    logic             restart;
    logic             mismatch;
    logic             overrun;

    assign fall    = sync_prev_q & ~sync_i;
    // A fall on a tick restarts immediately; otherwise it waits armed for the next tick
    assign restart = tick_i & (arm_q | fall);

    always_comb begin
        cnt_d    = cnt_q;
        arm_d    = arm_q;
        seen_d   = seen_q;
        ovr_d    = ovr_q;
        mismatch = 1'b0;
        overrun  = 1'b0;
        if (restart) begin
            // An edge arriving after an already-reported overrun is the same fault
            mismatch = seen_q & check_i & ~ovr_q & (cnt_q != LastCnt);
            cnt_d    = '0;
            arm_d    = 1'b0;
            seen_d   = 1'b1;
            ovr_d    = 1'b0;
        end else begin
            if (fall) begin
                arm_d = 1'b1;
            end
            if (tick_i) begin
                if (cnt_q != MaxCnt) begin
                    cnt_d = cnt_q + 1'b1;
                end
                overrun = CheckOverrun & seen_q & check_i & (cnt_q == LastCnt);
                if (overrun) begin
                    ovr_d = 1'b1;
                end
            end
        end
        err_d = mismatch | overrun;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_prev_q <= 1'b0;
            arm_q       <= 1'b0;
            seen_q      <= 1'b0;
            ovr_q       <= 1'b0;
            cnt_q       <= '0;
            restarted_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync_prev_q <= sync_i;
            arm_q       <= arm_d;
            seen_q      <= seen_d;
            ovr_q       <= ovr_d;
            cnt_q       <= cnt_d;
            restarted_q <= restart;
            err_q       <= err_d;
        end
    end

    assign restart_o   = restart;
    assign count_o     = cnt_q;
    assign restarted_o = restarted_q;
    assign err_o       = err_q;

endmodule

// File: rtl/vga_frame_receiver.sv
// VGA frame receiver: recovers pixel coordinates from the sync edges of a raster,
// checks line/frame periods, locks after one clean frame and emits {x, y, RGB}.
// Pipeline: input registers (edge k), counters (k+1), output registers (k+2).
// Ports:
//   clk_i    pixel clock
//   rst_ni   asynchronous active-low reset
//   bus      slave side of vga_frame_receiver_if (raster in, pixel stream out)
module vga_frame_receiver
    import vga_rx_pkg::*;
#(
    parameter int unsigned HActive = H_ACTIVE,
    parameter int unsigned HFp     = H_FP,
    parameter int unsigned HSync   = H_SYNC,
    parameter int unsigned HBp     = H_BP,
    parameter int unsigned VActive = V_ACTIVE,
    parameter int unsigned VFp     = V_FP,
    parameter int unsigned VSync   = V_SYNC,
    parameter int unsigned VBp     = V_BP
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    vga_frame_receiver_if.slave bus
);

    localparam int unsigned      HTotal = HActive + HFp + HSync + HBp;
    localparam int unsigned      VTotal = VActive + VFp + VSync + VBp;
    localparam logic [CNT_W-1:0] HLo    = CNT_W'(HSync + HBp);
    localparam logic [CNT_W-1:0] HHi    = CNT_W'(HSync + HBp + HActive - 1);
    localparam logic [CNT_W-1:0] VLo    = CNT_W'(VSync + VBp);
    localparam logic [CNT_W-1:0] VHi    = CNT_W'(VSync + VBp + VActive - 1);

    // Input stage, plus one extra delay for blank/colour to line up with the counters
    logic hsync_q, vsync_q, blank_q, blank_dly_q;
    rgb_t rgb_q, rgb_dly_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            blank_q     <= 1'b0;
            blank_dly_q <= 1'b0;
            rgb_q       <= '0;
            rgb_dly_q   <= '0;
        end else begin
            hsync_q     <= bus.hsync;
            vsync_q     <= bus.vsync;
            blank_q     <= bus.blank;
            blank_dly_q <= blank_q;
            rgb_q       <= {bus.red, bus.green, bus.blue};
            rgb_dly_q   <= rgb_q;
        end
    end

    rx_state_t        state_q, state_d;
    logic             h_fall;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             h_restarted, h_err;
    logic             v_restart, v_restarted, v_err;

    vga_period_counter #(
        .Width        (CNT_W),
        .Period       (HTotal),
        .CheckOverrun (1'b1)
    ) u_h_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sync_i      (hsync_q),
        .tick_i      (1'b1),
        .check_i     (1'b1),
        .restart_o   (h_fall),
        .count_o     (h_cnt),
        .restarted_o (h_restarted),
        .err_o       (h_err)
    );

    // Lines are counted on hsync falls; the first boundary after SEARCH is not checked
    vga_period_counter #(
        .Width        (CNT_W),
        .Period       (VTotal),
        .CheckOverrun (1'b0)
    ) u_v_cnt (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sync_i      (vsync_q),
        .tick_i      (h_fall),
        .check_i     (state_q != SEARCH),
        .restart_o   (v_restart),
        .count_o     (v_cnt),
        .restarted_o (v_restarted),
        .err_o       (v_err)
    );

    logic unused_ok;
    assign unused_ok = ^{h_restarted, v_restart};

    logic any_err;
    assign any_err = h_err | v_err;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEARCH:  if (v_restarted) state_d = MEASURE;
            MEASURE: begin
                if (any_err) begin
                    state_d = SEARCH;
                end else if (v_restarted) begin
                    state_d = LOCKED;
                end
            end
            LOCKED:  if (any_err) state_d = SEARCH;
            default: state_d = SEARCH;
        endcase
    end

    logic in_win;
    logic valid_d;
    assign in_win  = (h_cnt >= HLo) && (h_cnt <= HHi) && (v_cnt >= VLo) && (v_cnt <= VHi);
    // Next state gates validity so the pixel carrying an error is already dropped
    assign valid_d = (state_d == LOCKED) && in_win;

    logic             pix_valid_q, frame_start_q, line_err_q, frame_err_q, blank_err_q;
    logic [CNT_W-1:0] pix_x_q, pix_y_q;
    rgb_t             pix_rgb_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= SEARCH;
            pix_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            line_err_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            blank_err_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            pix_rgb_q     <= '0;
        end else begin
            state_q       <= state_d;
            pix_valid_q   <= valid_d;
            frame_start_q <= valid_d && (h_cnt == HLo) && (v_cnt == VLo);
            line_err_q    <= h_err;
            frame_err_q   <= v_err;
            if ((state_d == LOCKED) && (blank_dly_q != in_win)) begin
                blank_err_q <= 1'b1;
            end
            if (valid_d) begin
                pix_x_q   <= h_cnt - HLo;
                pix_y_q   <= v_cnt - VLo;
                pix_rgb_q <= rgb_dly_q;
            end
        end
    end

    assign bus.pix_valid   = pix_valid_q;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.pix_rgb     = pix_rgb_q;
    assign bus.frame_start = frame_start_q;
    assign bus.locked      = (state_q == LOCKED);
    assign bus.line_err    = line_err_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.blank_err   = blank_err_q;

endmodule

// File: tb/tb_vga_frame_receiver.sv
// Bench for vga_frame_receiver on a reduced raster (18 clocks/line, 12 lines/frame)
// so that many frames fit in a short run. The stimulus task pushes every pixel it
// expects the receiver to deliver; a monitor pops and compares on each pix_valid.
module tb_vga_frame_receiver;

    localparam int HA = 8, HF = 3, HS = 4, HB = 3;
    localparam int VA = 5, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int HLO = HS + HB;
    localparam int VLO = VS + VB;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [23:0] rgb;
        logic        fs;
    } px_t;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   line_err_cnt = 0;
    int   frame_err_cnt = 0;
    px_t  sb[$];

    always #5 clk = ~clk;

    vga_frame_receiver_if bus ();

    vga_frame_receiver #(
        .HActive (HA), .HFp (HF), .HSync (HS), .HBp (HB),
        .VActive (VA), .VFp (VF), .VSync (VS), .VBp (VB)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check1({tag, "_pix_valid"}, 32'(bus.pix_valid), 0);
        check1({tag, "_pix_x"}, 32'(bus.pix_x), 0);
        check1({tag, "_pix_y"}, 32'(bus.pix_y), 0);
        check1({tag, "_pix_rgb"}, 32'(bus.pix_rgb), 0);
        check1({tag, "_frame_start"}, 32'(bus.frame_start), 0);
        check1({tag, "_locked"}, 32'(bus.locked), 0);
        check1({tag, "_line_err"}, 32'(bus.line_err), 0);
        check1({tag, "_frame_err"}, 32'(bus.frame_err), 0);
        check1({tag, "_blank_err"}, 32'(bus.blank_err), 0);
    endtask

    // mode: 0 clean, 1 no hsync fall on line 7, 2 reset at line 7 hc 2,
    //       3 blank forced low at (x=1, y=2). early: vsync falls 5 clocks before frame end.
    task automatic run_frame(input int nlines, input bit exp_on, input int mode, input bit early);
        int          bchk;
        bit          act;
        logic [23:0] c;
        bchk = 0;
        for (int vc = 0; vc < nlines; vc++) begin
            for (int hc = 0; hc < HT; hc++) begin
                @(negedge clk);
                if (bchk > 0) begin
                    bchk--;
                    if (bchk == 1) check1("blank_err_before_latency", 32'(bus.blank_err), 0);
                    if (bchk == 0) check1("blank_err_after_2_cycles", 32'(bus.blank_err), 1);
                end
                if (mode == 2 && vc == 7 && hc == 2) begin
                    check1("locked_before_reset", 32'(bus.locked), 1);
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check_reset("async_reset");
                    return;
                end
                act = (hc >= HLO) && (hc < HLO + HA) && (vc >= VLO) && (vc < VLO + VA);
                c = 24'($urandom);
                bus.hsync = (hc >= HS) || (mode == 1 && vc == 7);
                bus.vsync = !((vc < VS) || (early && vc == nlines - 1 && hc >= HT - 5));
                bus.blank = act;
                if (mode == 3 && vc == 7 && hc == HLO + 1) begin
                    bus.blank = 1'b0;
                    bchk = 3;
                end
                bus.red   = c[23:16];
                bus.green = c[15:8];
                bus.blue  = c[7:0];
                if (exp_on && act && !((mode == 1 || mode == 2) && vc >= 7)) begin
                    sb.push_back('{x: 10'(hc - HLO), y: 10'(vc - VLO), rgb: c,
                                   fs: (hc == HLO && vc == VLO)});
                end
            end
        end
    endtask

    // Monitor: every delivered pixel must be the next one the stimulus expected
    always @(negedge clk) begin
        px_t got, exp;
        if (rst_n) begin
            if (bus.line_err) line_err_cnt++;
            if (bus.frame_err) frame_err_cnt++;
            if (bus.pix_valid) begin
                checks++;
                got = '{x: bus.pix_x, y: bus.pix_y, rgb: bus.pix_rgb, fs: bus.frame_start};
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL pixel_unexpected: got x=%0d y=%0d rgb=%h, required none",
                             got.x, got.y, got.rgb);
                end else begin
                    exp = sb.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL pixel: got x=%0d y=%0d rgb=%h fs=%0b, required x=%0d y=%0d rgb=%h fs=%0b",
                                 got.x, got.y, got.rgb, got.fs, exp.x, exp.y, exp.rgb, exp.fs);
                    end
                end
            end else if (bus.frame_start) begin
                checks++;
                errors++;
                $display("FAIL frame_start_without_pixel: got 1, required 0");
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        bus.blank = 1'b0;
        bus.red = 8'h0;
        bus.green = 8'h0;
        bus.blue = 8'h0;
        repeat (3) @(negedge clk);
        check_reset("power_on");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Power-up lock: first boundary -> MEASURE, second -> LOCKED
        run_frame(VT, 0, 0, 0);
        check1("locked_after_first_frame", 32'(bus.locked), 0);
        run_frame(VT, 1, 0, 0);
        check1("locked_after_second_boundary", 32'(bus.locked), 1);
        run_frame(VT, 1, 0, 0);
        check1("clean_frame_all_pixels", 32'(sb.size()), 0);
        check1("clean_no_line_err", 32'(line_err_cnt), 0);

        // Missing hsync fall
        run_frame(VT, 1, 1, 0);
        check1("drop_line_err_once", 32'(line_err_cnt), 1);
        check1("drop_unlocked", 32'(bus.locked), 0);
        check1("drop_pixels_before_error", 32'(sb.size()), 0);
        run_frame(VT, 0, 0, 0);
        check1("drop_measure_not_locked", 32'(bus.locked), 0);
        run_frame(VT, 1, 0, 0);
        check1("drop_relocked", 32'(bus.locked), 1);
        check1("drop_line_err_still_once", 32'(line_err_cnt), 1);

        // Short frame
        run_frame(VT - 1, 1, 0, 0);
        check1("short_frame_still_locked", 32'(bus.locked), 1);
        check1("short_frame_no_err_yet", 32'(frame_err_cnt), 0);
        run_frame(VT, 0, 0, 0);
        check1("short_frame_err", 32'(frame_err_cnt), 1);
        check1("short_frame_unlocked", 32'(bus.locked), 0);
        run_frame(VT, 0, 0, 0);
        check1("short_frame_measure", 32'(bus.locked), 0);

        // Blank disagreement while locked
        check1("blank_err_clear_before", 32'(bus.blank_err), 0);
        run_frame(VT, 1, 3, 0);
        check1("blank_locked", 32'(bus.locked), 1);
        check1("blank_pixels_delivered", 32'(sb.size()), 0);
        run_frame(VT, 1, 0, 0);
        check1("blank_err_sticky", 32'(bus.blank_err), 1);

        // Reset mid-line while locked, then relock as from power-up
        run_frame(VT, 1, 2, 0);
        check1("reset_no_pending_pixels", 32'(sb.size()), 0);
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset_hold");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(VT, 0, 0, 0);
        check1("relock_first_frame", 32'(bus.locked), 0);

        // Early vsync at the end of this frame must map y=0 to the same line
        run_frame(VT, 1, 0, 1);
        check1("relock_second_boundary", 32'(bus.locked), 1);
        run_frame(VT, 1, 0, 0);
        check1("early_vsync_locked", 32'(bus.locked), 1);
        check1("early_vsync_pixels", 32'(sb.size()), 0);
        check1("final_line_err_count", 32'(line_err_cnt), 1);
        check1("final_frame_err_count", 32'(frame_err_cnt), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
